// File: rtl/diff_window_stats.sv
// Windowed statistics (sum, min, max, count) over signed difference samples.
// Collects up to 2**WIN_LOG2 samples, then holds the result until the consumer takes it.
module diff_window_stats #(
  parameter int WIDTH    = 32,
  parameter int WIN_LOG2 = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_diff,
  output logic                         in_ready,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH+WIN_LOG2-1:0]    out_sum,
  output logic [WIDTH-1:0]             out_min,
  output logic [WIDTH-1:0]             out_max,
  output logic [WIN_LOG2:0]            out_count,
  output logic                         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; the producer holds data stable while valid=1 and ready=0.

  localparam int SW = WIDTH + WIN_LOG2;
  localparam logic [WIN_LOG2:0] WIN_N = {1'b1, {WIN_LOG2{1'b0}}};

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t state, state_nxt;

  logic [WIN_LOG2:0] count, count_nxt;
  logic [SW-1:0]     sum, sum_nxt;
  logic [WIDTH-1:0]  min_q, min_nxt;
  logic [WIDTH-1:0]  max_q, max_nxt;
  logic [SW-1:0]     sample_ext;
  logic              accept;
  logic              close;

  assign accept     = in_valid && (state == ACCUM);
  assign sample_ext = {{WIN_LOG2{in_diff[WIDTH-1]}}, in_diff};

  always_comb begin
    count_nxt = count;
    sum_nxt   = sum;
    min_nxt   = min_q;
    max_nxt   = max_q;
    if (accept) begin
      count_nxt = count + {{WIN_LOG2{1'b0}}, 1'b1};
      sum_nxt   = sum + sample_ext;
      // The first sample of a window seeds both extremes.
      if (count == '0 || $signed(in_diff) < $signed(min_q)) min_nxt = in_diff;
      if (count == '0 || $signed(in_diff) > $signed(max_q)) max_nxt = in_diff;
    end
  end

  assign close = (state == ACCUM) &&
                 ((accept && count_nxt == WIN_N) || (flush && (count != '0 || accept)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (close) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      sum       <= '0;
      min_q     <= '0;
      max_q     <= '0;
      out_sum   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      out_count <= '0;
    end else begin
      if (state == HOLD) begin
        if (out_ready) begin
          count <= '0;
          sum   <= '0;
          min_q <= '0;
          max_q <= '0;
        end
      end else begin
        count <= count_nxt;
        sum   <= sum_nxt;
        min_q <= min_nxt;
        max_q <= max_nxt;
      end
      if (close) begin
        out_sum   <= sum_nxt;
        out_min   <= min_nxt;
        out_max   <= max_nxt;
        out_count <= count_nxt;
      end
    end
  end

endmodule

// File: tb/tb_diff_window_stats.sv
// Bench for diff_window_stats: directed scenarios plus random traffic, scored
// against a window-list reference model through an expected-result queue.
module tb_diff_window_stats;

  localparam int W  = 32;
  localparam int L  = 4;
  localparam int N  = 1 << L;
  localparam int SW = W + L;
  localparam int EW = (L + 1) + SW + W + W;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_diff;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] out_sum;
  logic [W-1:0]  out_min;
  logic [W-1:0]  out_max;
  logic [L:0]    out_count;
  logic          dbg_state;

  diff_window_stats #(.WIDTH(W), .WIN_LOG2(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_diff(in_diff),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_min(out_min),
    .out_max(out_max), .out_count(out_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model: the samples of the open window and whether a result is held
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  win[$];
  bit            m_hold = 1'b0;
  int            results_seen = 0;

  task automatic model_edge();
    longint s;
    logic signed [W-1:0] mn, mx;
    logic [SW-1:0] s_t;
    logic [L:0] c_t;
    if (reset) begin
      m_hold = 1'b0;
      win.delete();
      exp_q.delete();
    end else if (!m_hold) begin
      if (in_valid) win.push_back(in_diff);
      if (win.size() == N || (flush && win.size() > 0)) begin
        s = 0;
        mn = win[0];
        mx = win[0];
        foreach (win[i]) begin
          s += longint'($signed(win[i]));
          if ($signed(win[i]) < mn) mn = win[i];
          if ($signed(win[i]) > mx) mx = win[i];
        end
        s_t = s[SW-1:0];
        c_t = (L+1)'(win.size());
        exp_q.push_back({c_t, s_t, mn, mx});
        win.delete();
        m_hold = 1'b1;
      end
    end else if (out_ready) begin
      m_hold = 1'b0;
    end
  endtask

  // driver: present one cycle of inputs, then advance the model past the edge
  task automatic cyc(input bit v, input logic [W-1:0] d, input bit f,
                     input bit r, input bit rst);
    in_valid  = v;
    in_diff   = d;
    flush     = f;
    out_ready = r;
    reset     = rst;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic check(input string name, input logic [SW-1:0] got,
                       input logic [SW-1:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_sum"},   out_sum, '0);
    check({tag, "_min"},   SW'(out_min), '0);
    check({tag, "_max"},   SW'(out_max), '0);
    check({tag, "_count"}, SW'(out_count), '0);
    check({tag, "_in_ready"}, SW'(in_ready), SW'(1));
    check({tag, "_out_valid"}, SW'(out_valid), '0);
  endtask

  // scoreboard monitor: handshake flags follow the model state; results are
  // compared against the head of the queue and popped on transfer
  always @(negedge clk) begin
    vectors++;
    if (in_ready !== !m_hold || out_valid !== m_hold) begin
      miscompares++;
      $display("FAIL flags: in_ready=%b out_valid=%b want in_ready=%b out_valid=%b",
               in_ready, out_valid, !m_hold, m_hold);
    end
    if (out_valid === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL result_unexpected: got cnt=%0d sum=%h min=%h max=%h want none",
                 out_count, out_sum, out_min, out_max);
      end else if ({out_count, out_sum, out_min, out_max} !== exp_q[0]) begin
        miscompares++;
        $display("FAIL result: got cnt=%0d sum=%h min=%h max=%h want cnt=%0d sum=%h min=%h max=%h",
                 out_count, out_sum, out_min, out_max,
                 exp_q[0][EW-1 -: L+1], exp_q[0][2*W+SW-1 -: SW],
                 exp_q[0][2*W-1 -: W], exp_q[0][W-1:0]);
      end
      if (out_ready === 1'b1 && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        results_seen++;
      end
    end
  end

  initial begin
    int base;
    in_valid = 0; in_diff = '0; flush = 0; out_ready = 1; reset = 1;
    cyc(0, '0, 0, 1, 1);
    cyc(1, 32'h1234, 1, 1, 1);
    check_cleared("reset");

    // full window 1..16
    base = results_seen;
    for (int i = 1; i <= N; i++) cyc(1, W'(i), 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    check("full_window_results", SW'(results_seen - base), SW'(1));

    // signed extremes
    for (int i = 0; i < N; i++) cyc(1, 32'h8000_0000, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);

    // backpressure: result held with in_valid asserted
    base = results_seen;
    for (int i = 0; i < N; i++) cyc(1, W'(100 + i), 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'hdead_beef, 0, 0, 0);
    cyc(1, 32'd5, 0, 1, 0);
    cyc(1, 32'd5, 1, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    check("backpressure_results", SW'(results_seen - base), SW'(2));

    // flush with partial window, then flush on an empty window
    cyc(1, -32'sd3, 0, 1, 0);
    cyc(1, 32'd7, 0, 1, 0);
    cyc(1, 32'd2, 1, 1, 0);
    cyc(0, '0, 0, 1, 0);
    base = results_seen;
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 1, 0);
    check("empty_flush_results", SW'(results_seen - base), '0);

    // reset mid-window
    for (int i = 0; i < 9; i++) cyc(1, W'(1000 + i), 0, 1, 0);
    cyc(0, '0, 0, 1, 1);
    check_cleared("midreset");
    for (int i = 0; i < N; i++) cyc(1, W'(-i), 0, 1, 0);
    cyc(0, '0, 0, 1, 0);
    cyc(0, '0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = 32'h8000_0000;
        1:       d = 32'h7fff_ffff;
        default: d = $urandom;
      endcase
      cyc($urandom_range(0, 3) != 0, d, $urandom_range(0, 9) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, 1, 0);
    check("queue_drained", SW'(exp_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
